plab5_mcore_mem_req_arb: RTL and testbench
==========================================

Name: plab5_mcore_mem_req_arb

Overview:
Two-requester, domain-aware arbiter that shares one memory-network request injection port between two cores/caches. It tags each granted request with the requester id in the opaque MSB and registers it into a one-entry output stage. It tracks outstanding requests per requester and steers network responses back by that tag. It sits between the per-core cache request ports and one request/response port pair of the memory network.

Parameters:
p_mem_opaque_nbits, 8, opaque field width (o); MSB reserved for requester id
p_mem_addr_nbits, 32, address width (a)
p_mem_data_nbits, 32, data width (d)
p_max_outstanding, 4, per-requester in-flight request limit (>=1)
c_req_nbits, 3+o+a+2+d, request msg width (rq); derived
c_resp_nbits, 3+o+2+d, response msg width (rs); derived

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
mode  in  1  1 = secure mode: requester 0 strict priority
req_in_msg_r0 / req_in_msg_r1  in  rq  request from requester 0/1
req_in_domain_r0 / req_in_domain_r1  in  1  security domain of request
req_in_val_r0 / req_in_val_r1  in  1  request valid
req_in_rdy_r0 / req_in_rdy_r1  out  1  request accepted this cycle
req_out_msg  out  rq  tagged request to network
req_out_domain  out  1  domain of req_out_msg
req_out_val  out  1  output stage valid
req_out_rdy  in  1  network ready
resp_in_msg  in  rs  response from network
resp_in_val  in  1  response valid
resp_in_rdy  out  1  response consumed
resp_in_fail  in  1  access-denied flag
resp_out_msg_r0 / resp_out_msg_r1  out  rs  untagged response
resp_out_val_r0 / resp_out_val_r1  out  1  response valid
resp_out_rdy_r0 / resp_out_rdy_r1  in  1  requester ready
resp_out_fail_r0 / resp_out_fail_r1  out  1  fail flag passthrough
err_unexp_resp  out  1  sticky: response arrived for requester with zero outstanding

Behaviour:
- Reset (sync, high): req_out_val=0, req_out_msg=0, req_out_domain=0, prio pointer=0, both counters=0, err_unexp_resp=0. Any buffered request is dropped.
- Eligibility: eligible_X = req_in_val_rX & (cnt_X < p_max_outstanding).
- Output stage free when ~req_out_val | req_out_rdy.
- Grant, mode=0: round-robin. If both eligible, prio wins. After a grant to X, prio <= ~X. No grant leaves prio unchanged.
- Grant, mode=1: requester 0 always wins when eligible; prio is not updated.
- req_in_rdy_rX = grant_X & free. This is combinational from val, counters, mode and req_out_rdy. At most one rdy high per cycle.
- On accept, the output register loads msg with opaque field [rq-4 -: o] MSB forced to X. req_out_domain loads req_in_domain_rX. Latency is 1 cycle. Back-to-back accepts give full throughput when req_out_rdy=1.
- Output held stable while req_out_val & ~req_out_rdy.
- Response steer: id = resp_in_msg[rs-4]. resp_out_val_rid = resp_in_val; the other val is 0.
- resp_out_msg_rX = resp_in_msg with tag bit cleared. Fail passes through. resp_in_rdy = resp_out_rdy_rid. The response path is combinational.
- Counter per X: +1 on req accept, -1 on resp_out_val_rX & resp_out_rdy_rX. Both in the same cycle leaves it unchanged. Counter width is $clog2(p_max_outstanding+1).
- A response delivered to X while cnt_X=0 keeps cnt at 0 and sets err_unexp_resp.
- Requesters must drive opaque MSB=0. A nonzero MSB is overwritten.

Optional Feature:
PLAB5_MCORE_MEM_REQ_ARB_PERF_EN:
- Defined: adds outputs perf_grant_r0 and perf_grant_r1 (32 bits each) and perf_stall (32 bits).
- perf_grant_rX counts accepts per requester.
- perf_stall counts cycles with req_out_val & ~req_out_rdy.
- All three wrap modulo 2^32 and clear on reset.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - the opaque-field offset and response-tag offset macros, built on the VC mem msg widths;
  - the requester-id constants R0=0 and R1=1.
- One natural sub-module: plab5_mcore_rr_arb2, the 2-input round-robin arbiter with priority register and strict-priority override.
- Counters and output register stay in the top.

Test Plan:
- Reset, then both requesters valid continuously with req_out_rdy=1, mode=0 -> grants alternate r0,r1,r0,r1. req_out_msg opaque MSB follows 0,1,0,1. req_out_val first rises 1 cycle after the first accept.
- mode=1, both valid -> r0 granted every cycle and r1 never, until r0 reaches cnt=4. Then r1 is granted.
- p_max_outstanding=4, r0 issues 4 requests with no responses -> req_in_rdy_r0=0 on the 5th. One response with tag 0 and resp_out_rdy_r0=1 -> r0 accepted next cycle.
- req_out_rdy=0 for 3 cycles with the output valid -> req_out_msg/domain are stable, and both req_in_rdy are 0 for those 3 cycles.
- resp_in_msg with tag bit 1 and fail=1, resp_out_rdy_r1=0 -> resp_out_val_r1=1 and resp_in_rdy=0 until rdy_r1 rises. Delivered msg has tag bit 0 and fail_r1=1.
- Response tag 0 with cnt_0=0 -> err_unexp_resp=1 and stays 1. Sync reset then clears it.

Source files
------------

// File: rtl/plab5_mcore_mem_req_arb_pkg.sv
// rtl/plab5_mcore_mem_req_arb_pkg.sv - shared widths, field offsets and requester ids
package plab5_mcore_mem_req_arb_pkg;

  localparam logic R0 = 1'b0;
  localparam logic R1 = 1'b1;

  typedef enum logic {PRIO_R0 = 1'b0, PRIO_R1 = 1'b1} prio_e;

  function automatic int req_nbits(int o, int a, int d);
    return 3 + o + a + 2 + d;
  endfunction

  function automatic int resp_nbits(int o, int d);
    return 3 + o + 2 + d;
  endfunction

  // Opaque MSB sits just below the 3-bit type field in both message formats
  function automatic int req_opaque_msb(int o, int a, int d);
    return req_nbits(o, a, d) - 4;
  endfunction

  function automatic int resp_tag_bit(int o, int d);
    return resp_nbits(o, d) - 4;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_req_arb_if.sv
// rtl/plab5_mcore_mem_req_arb_if.sv - bus bundle; perf ports under PLAB5_MCORE_MEM_REQ_ARB_PERF_EN
interface plab5_mcore_mem_req_arb_if
  import plab5_mcore_mem_req_arb_pkg::*;
#(
  parameter int p_mem_opaque_nbits = 8,
  parameter int p_mem_addr_nbits   = 32,
  parameter int p_mem_data_nbits   = 32
);
  localparam int c_req_nbits  = req_nbits(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits);
  localparam int c_resp_nbits = resp_nbits(p_mem_opaque_nbits, p_mem_data_nbits);

  logic                    mode;
  logic [c_req_nbits-1:0]  req_in_msg_r0, req_in_msg_r1;
  logic                    req_in_domain_r0, req_in_domain_r1;
  logic                    req_in_val_r0, req_in_val_r1;
  logic                    req_in_rdy_r0, req_in_rdy_r1;
  logic [c_req_nbits-1:0]  req_out_msg;
  logic                    req_out_domain;
  logic                    req_out_val;
  logic                    req_out_rdy;
  logic [c_resp_nbits-1:0] resp_in_msg;
  logic                    resp_in_val;
  logic                    resp_in_rdy;
  logic                    resp_in_fail;
  logic [c_resp_nbits-1:0] resp_out_msg_r0, resp_out_msg_r1;
  logic                    resp_out_val_r0, resp_out_val_r1;
  logic                    resp_out_rdy_r0, resp_out_rdy_r1;
  logic                    resp_out_fail_r0, resp_out_fail_r1;
  logic                    err_unexp_resp;
`ifdef PLAB5_MCORE_MEM_REQ_ARB_PERF_EN
  logic [31:0]             perf_grant_r0, perf_grant_r1, perf_stall;
`endif

  modport slave (
    input  mode,
    input  req_in_msg_r0, req_in_msg_r1, req_in_domain_r0, req_in_domain_r1,
    input  req_in_val_r0, req_in_val_r1,
    output req_in_rdy_r0, req_in_rdy_r1,
    output req_out_msg, req_out_domain, req_out_val,
    input  req_out_rdy,
    input  resp_in_msg, resp_in_val, resp_in_fail,
    output resp_in_rdy,
    output resp_out_msg_r0, resp_out_msg_r1, resp_out_val_r0, resp_out_val_r1,
    input  resp_out_rdy_r0, resp_out_rdy_r1,
    output resp_out_fail_r0, resp_out_fail_r1,
`ifdef PLAB5_MCORE_MEM_REQ_ARB_PERF_EN
    output perf_grant_r0, perf_grant_r1, perf_stall,
`endif
    output err_unexp_resp
  );

  modport master (
    output mode,
    output req_in_msg_r0, req_in_msg_r1, req_in_domain_r0, req_in_domain_r1,
    output req_in_val_r0, req_in_val_r1,
    input  req_in_rdy_r0, req_in_rdy_r1,
    input  req_out_msg, req_out_domain, req_out_val,
    output req_out_rdy,
    output resp_in_msg, resp_in_val, resp_in_fail,
    input  resp_in_rdy,
    input  resp_out_msg_r0, resp_out_msg_r1, resp_out_val_r0, resp_out_val_r1,
    output resp_out_rdy_r0, resp_out_rdy_r1,
    input  resp_out_fail_r0, resp_out_fail_r1,
`ifdef PLAB5_MCORE_MEM_REQ_ARB_PERF_EN
    input  perf_grant_r0, perf_grant_r1, perf_stall,
`endif
    input  err_unexp_resp
  );

endinterface

// File: rtl/plab5_mcore_rr_arb2.sv
// rtl/plab5_mcore_rr_arb2.sv - two-input round-robin arbiter with strict-priority override
module plab5_mcore_rr_arb2
  import plab5_mcore_mem_req_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  prio_e prio, prio_next;

  always_ff @(posedge clk) begin
    if (reset) prio <= PRIO_R0;
    else       prio <= prio_next;
  end

  // Priority only moves when a grant is actually taken in round-robin mode
  always_comb begin
    grant     = 2'b00;
    prio_next = prio;
    if (mode) begin
      grant[0] = req[0];
      grant[1] = req[1] & ~req[0];
    end else if (req == 2'b11) begin
      grant = (prio == PRIO_R0) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
    if (!mode && en && (grant != 2'b00))
      prio_next = grant[0] ? PRIO_R1 : PRIO_R0;
  end

endmodule

// File: rtl/plab5_mcore_mem_req_arb.sv
// rtl/plab5_mcore_mem_req_arb.sv - two-requester tagged request arbiter with response steering
// Optional perf counters enabled by PLAB5_MCORE_MEM_REQ_ARB_PERF_EN.
module plab5_mcore_mem_req_arb
  import plab5_mcore_mem_req_arb_pkg::*;
#(
  parameter int p_mem_opaque_nbits = 8,
  parameter int p_mem_addr_nbits   = 32,
  parameter int p_mem_data_nbits   = 32,
  parameter int p_max_outstanding  = 4
)(
  input  logic                       clk,
  input  logic                       reset,
  plab5_mcore_mem_req_arb_if.slave   bus
);
  localparam int c_req_nbits  = req_nbits(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits);
  localparam int c_resp_nbits = resp_nbits(p_mem_opaque_nbits, p_mem_data_nbits);
  localparam int c_req_tag    = req_opaque_msb(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits);
  localparam int c_resp_tag   = resp_tag_bit(p_mem_opaque_nbits, p_mem_data_nbits);
  localparam int c_cnt_nbits  = $clog2(p_max_outstanding + 1);
  localparam logic [c_cnt_nbits-1:0] c_max = c_cnt_nbits'(p_max_outstanding);
  localparam logic [c_cnt_nbits-1:0] c_one = c_cnt_nbits'(1);

  logic [c_cnt_nbits-1:0]  cnt [2];
  logic [1:0]              eligible, grant, accept, resp_val, deliver;
  logic                    free, resp_id, sel_domain;
  logic [c_req_nbits-1:0]  sel_msg;
  logic [c_resp_nbits-1:0] resp_msg;
  logic                    out_val, out_domain, err;
  logic [c_req_nbits-1:0]  out_msg;

  assign eligible[0] = bus.req_in_val_r0 && (cnt[0] < c_max);
  assign eligible[1] = bus.req_in_val_r1 && (cnt[1] < c_max);
  assign free        = !out_val || bus.req_out_rdy;

  plab5_mcore_rr_arb2 arb (
    .clk   (clk),
    .reset (reset),
    .mode  (bus.mode),
    .req   (eligible),
    .en    (free),
    .grant (grant)
  );

  assign accept            = grant & {2{free}};
  assign bus.req_in_rdy_r0 = accept[0];
  assign bus.req_in_rdy_r1 = accept[1];

  // Requester id overwrites whatever the requester left in the opaque MSB
  always_comb begin
    sel_msg             = accept[1] ? bus.req_in_msg_r1 : bus.req_in_msg_r0;
    sel_domain          = accept[1] ? bus.req_in_domain_r1 : bus.req_in_domain_r0;
    sel_msg[c_req_tag]  = accept[1] ? R1 : R0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_val    <= 1'b0;
      out_msg    <= '0;
      out_domain <= 1'b0;
    end else if (free) begin
      out_val <= |accept;
      if (|accept) begin
        out_msg    <= sel_msg;
        out_domain <= sel_domain;
      end
    end
  end

  assign bus.req_out_val    = out_val;
  assign bus.req_out_msg    = out_msg;
  assign bus.req_out_domain = out_domain;

  always_comb begin
    resp_msg             = bus.resp_in_msg;
    resp_msg[c_resp_tag] = 1'b0;
  end

  assign resp_id              = bus.resp_in_msg[c_resp_tag];
  assign resp_val[0]          = bus.resp_in_val && (resp_id == R0);
  assign resp_val[1]          = bus.resp_in_val && (resp_id == R1);
  assign deliver[0]           = resp_val[0] && bus.resp_out_rdy_r0;
  assign deliver[1]           = resp_val[1] && bus.resp_out_rdy_r1;
  assign bus.resp_out_val_r0  = resp_val[0];
  assign bus.resp_out_val_r1  = resp_val[1];
  assign bus.resp_out_msg_r0  = resp_msg;
  assign bus.resp_out_msg_r1  = resp_msg;
  assign bus.resp_out_fail_r0 = bus.resp_in_fail;
  assign bus.resp_out_fail_r1 = bus.resp_in_fail;
  assign bus.resp_in_rdy      = resp_id ? bus.resp_out_rdy_r1 : bus.resp_out_rdy_r0;

  // A delivery against an empty counter is flagged and never underflows
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
      err    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i] && !deliver[i])
          cnt[i] <= cnt[i] + c_one;
        else if (!accept[i] && deliver[i] && (cnt[i] != '0))
          cnt[i] <= cnt[i] - c_one;
      end
      if ((deliver[0] && (cnt[0] == '0)) || (deliver[1] && (cnt[1] == '0)))
        err <= 1'b1;
    end
  end

  assign bus.err_unexp_resp = err;

`ifdef PLAB5_MCORE_MEM_REQ_ARB_PERF_EN
  logic [31:0] perf_grant_r0, perf_grant_r1, perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grant_r0 <= '0;
      perf_grant_r1 <= '0;
      perf_stall    <= '0;
    end else begin
      if (accept[0])                    perf_grant_r0 <= perf_grant_r0 + 32'd1;
      if (accept[1])                    perf_grant_r1 <= perf_grant_r1 + 32'd1;
      if (out_val && !bus.req_out_rdy)  perf_stall    <= perf_stall + 32'd1;
    end
  end

  assign bus.perf_grant_r0 = perf_grant_r0;
  assign bus.perf_grant_r1 = perf_grant_r1;
  assign bus.perf_stall    = perf_stall;
`endif

endmodule

// File: tb/tb_plab5_mcore_mem_req_arb.sv
// tb/tb_plab5_mcore_mem_req_arb.sv - randomized scoreboard bench for the request arbiter
module tb_plab5_mcore_mem_req_arb;
  localparam int O = 8, A = 32, D = 32, MAXO = 4;
  localparam int RQ = 3 + O + A + 2 + D;
  localparam int RS = 3 + O + 2 + D;
  localparam int RQT = RQ - 4;
  localparam int RST = RS - 4;

  typedef struct { logic [RQ-1:0] msg; logic dom; } req_t;
  typedef struct { logic id; logic [RS-1:0] msg; logic fail; } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  plab5_mcore_mem_req_arb_if #(.p_mem_opaque_nbits(O), .p_mem_addr_nbits(A), .p_mem_data_nbits(D)) bus ();

  plab5_mcore_mem_req_arb #(
    .p_mem_opaque_nbits(O), .p_mem_addr_nbits(A), .p_mem_data_nbits(D), .p_max_outstanding(MAXO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  req_t  exp_req[$];
  resp_t exp_resp[$];
  int    net_q[$];
  resp_t mon_e;

  int   m_cnt[2];
  int   m_grants[2];
  int   m_stall;
  logic m_prio, m_out_val, m_out_id, m_err;
  logic r_active, r_id;
  logic m_mode, force_unexp;
  int   p_val0, p_val1, p_outrdy, p_resp, p_resprdy;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit chance(int pct);
    return $urandom_range(99) < pct;
  endfunction

  // Output-side monitors: compare whatever the DUT presents against the queues
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.req_out_val) begin
        if (exp_req.size() == 0) check("req_out_unexpected", 1, 0);
        else begin
          check("req_out_msg", bus.req_out_msg, exp_req[0].msg);
          check("req_out_domain", bus.req_out_domain, exp_req[0].dom);
          if (bus.req_out_rdy) void'(exp_req.pop_front());
        end
      end
      if (bus.resp_out_val_r0 || bus.resp_out_val_r1) begin
        if (exp_resp.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          mon_e = exp_resp[0];
          check("resp_out_val_r0", bus.resp_out_val_r0, !mon_e.id);
          check("resp_out_val_r1", bus.resp_out_val_r1, mon_e.id);
          check("resp_out_msg", mon_e.id ? bus.resp_out_msg_r1 : bus.resp_out_msg_r0, mon_e.msg);
          check("resp_out_fail", mon_e.id ? bus.resp_out_fail_r1 : bus.resp_out_fail_r0, mon_e.fail);
          check("resp_in_rdy", bus.resp_in_rdy, mon_e.id ? bus.resp_out_rdy_r1 : bus.resp_out_rdy_r0);
          if (mon_e.id ? bus.resp_out_rdy_r1 : bus.resp_out_rdy_r0) void'(exp_resp.pop_front());
        end
      end else if (exp_resp.size() != 0) begin
        check("resp_missing", 0, 1);
      end
    end
  end

  task automatic drive_idle();
    bus.mode = 1'b0;
    bus.req_in_val_r0 = 1'b0; bus.req_in_val_r1 = 1'b0;
    bus.req_in_msg_r0 = '0;   bus.req_in_msg_r1 = '0;
    bus.req_in_domain_r0 = 1'b0; bus.req_in_domain_r1 = 1'b0;
    bus.req_out_rdy = 1'b0;
    bus.resp_in_msg = '0; bus.resp_in_val = 1'b0; bus.resp_in_fail = 1'b0;
    bus.resp_out_rdy_r0 = 1'b0; bus.resp_out_rdy_r1 = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b1;
    drive_idle();
    @(posedge clk); @(posedge clk); #1;
    exp_req.delete(); exp_resp.delete(); net_q.delete();
    m_cnt[0] = 0; m_cnt[1] = 0; m_grants[0] = 0; m_grants[1] = 0; m_stall = 0;
    m_prio = 1'b0; m_out_val = 1'b0; m_out_id = 1'b0; m_err = 1'b0;
    r_active = 1'b0; force_unexp = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("reset_req_out_val", bus.req_out_val, 0);
    check("reset_req_out_msg", bus.req_out_msg, 0);
    check("reset_req_out_domain", bus.req_out_domain, 0);
    check("reset_err_unexp", bus.err_unexp_resp, 0);
  endtask

  task automatic step();
    logic [95:0]   rnd;
    logic [RS-1:0] rm;
    logic e0, e1, free, acc, win, delivered;
    resp_t r;
    @(posedge clk); #1;
    bus.mode = m_mode;
    rnd = {$urandom(), $urandom(), $urandom()};
    bus.req_in_msg_r0 = rnd[RQ-1:0];
    rnd = {$urandom(), $urandom(), $urandom()};
    bus.req_in_msg_r1 = rnd[RQ-1:0];
    bus.req_in_domain_r0 = 1'($urandom_range(1));
    bus.req_in_domain_r1 = 1'($urandom_range(1));
    bus.req_in_val_r0 = chance(p_val0);
    bus.req_in_val_r1 = chance(p_val1);
    bus.req_out_rdy = chance(p_outrdy);
    bus.resp_out_rdy_r0 = chance(p_resprdy);
    bus.resp_out_rdy_r1 = chance(p_resprdy);
    if (!r_active) begin
      if (force_unexp) begin
        r_active = 1'b1; r_id = 1'b0; force_unexp = 1'b0;
      end else if (net_q.size() > 0 && chance(p_resp)) begin
        int k = $urandom_range(net_q.size() - 1);
        r_id = net_q[k][0];
        net_q.delete(k);
        r_active = 1'b1;
      end
      if (r_active) begin
        rnd = {$urandom(), $urandom(), $urandom()};
        rm = rnd[RS-1:0];
        rm[RST] = r_id;
        bus.resp_in_msg = rm;
        bus.resp_in_fail = 1'($urandom_range(1));
        r.id = r_id; r.msg = rm; r.msg[RST] = 1'b0; r.fail = bus.resp_in_fail;
        exp_resp.push_back(r);
      end
    end
    bus.resp_in_val = r_active;
    @(negedge clk);
    e0 = bus.req_in_val_r0 && (m_cnt[0] < MAXO);
    e1 = bus.req_in_val_r1 && (m_cnt[1] < MAXO);
    free = !m_out_val || bus.req_out_rdy;
    acc = free && (e0 || e1);
    win = (e0 && e1) ? (m_mode ? 1'b0 : m_prio) : e1;
    check("req_in_rdy_r0", bus.req_in_rdy_r0, acc && !win);
    check("req_in_rdy_r1", bus.req_in_rdy_r1, acc && win);
    check("req_out_val", bus.req_out_val, m_out_val);
    check("err_unexp_resp", bus.err_unexp_resp, m_err);
    if (m_out_val && bus.req_out_rdy) net_q.push_back(int'(m_out_id));
    if (m_out_val && !bus.req_out_rdy) m_stall++;
    delivered = r_active && (r_id ? bus.resp_out_rdy_r1 : bus.resp_out_rdy_r0);
    for (int x = 0; x < 2; x++) begin
      bit inc = acc && (int'(win) == x);
      bit dec = delivered && (int'(r_id) == x);
      if (dec && m_cnt[x] == 0) m_err = 1'b1;
      if (inc && !dec) m_cnt[x]++;
      else if (dec && !inc && m_cnt[x] > 0) m_cnt[x]--;
    end
    if (delivered) r_active = 1'b0;
    if (free) begin
      m_out_val = acc;
      if (acc) begin
        req_t q;
        q.msg = win ? bus.req_in_msg_r1 : bus.req_in_msg_r0;
        q.msg[RQT] = win;
        q.dom = win ? bus.req_in_domain_r1 : bus.req_in_domain_r0;
        exp_req.push_back(q);
        m_out_id = win;
        m_grants[win]++;
        if (!m_mode) m_prio = !win;
      end
    end
  endtask

  task automatic set_knobs(int v0, int v1, int ordy, int rsp, int rrdy);
    p_val0 = v0; p_val1 = v1; p_outrdy = ordy; p_resp = rsp; p_resprdy = rrdy;
  endtask

  task automatic drain();
    int n = 0;
    set_knobs(0, 0, 100, 100, 100);
    while ((m_cnt[0] != 0 || m_cnt[1] != 0 || r_active || m_out_val || net_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    m_mode = 1'b0;
    reset_dut();

    // Round-robin with both requesters saturating until both hit the in-flight limit
    m_mode = 1'b0; set_knobs(100, 100, 100, 0, 100);
    repeat (12) step();
    drain();

    // Strict priority: r0 monopolises until its limit, then r1 gets through
    m_mode = 1'b1; set_knobs(100, 100, 100, 0, 100);
    repeat (12) step();
    drain();

    for (int ph = 0; ph < 20; ph++) begin
      m_mode = 1'($urandom_range(1));
      set_knobs($urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(30, 100),
                $urandom_range(10, 80), $urandom_range(30, 100));
      repeat (100) step();
    end
    drain();

`ifdef PLAB5_MCORE_MEM_REQ_ARB_PERF_EN
    check("perf_grant_r0", bus.perf_grant_r0, 32'(m_grants[0]));
    check("perf_grant_r1", bus.perf_grant_r1, 32'(m_grants[1]));
    check("perf_stall", bus.perf_stall, 32'(m_stall));
`endif

    // Response for a requester with nothing outstanding must latch the sticky error
    set_knobs(0, 0, 100, 0, 100);
    force_unexp = 1'b1;
    repeat (6) step();
    check("err_sticky", bus.err_unexp_resp, 1);
    reset_dut();
    set_knobs(50, 50, 100, 50, 100);
    repeat (20) step();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
